// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if
// Bundles the copy engine's host control/status signals and its RAM access
// port.
//   master : the copy engine. Takes the host controls and RAM read data;
//            drives status and the RAM access signals.
//   slave  : the host and RAM side.
// Signals:
//   start, abort, src_addr, dst_addr, length   host -> engine
//   busy, done, err, words_done                engine -> host
//   mem_en_r, mem_en_w, mem_address, mem_wdata engine -> RAM
//   mem_rdata                                  RAM -> engine
interface dma_copy_engine_if #(
    parameter int ADDR_W = 65,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 7
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic              err;
    logic [LEN_W-1:0]  words_done;
    logic              mem_en_r;
    logic              mem_en_w;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  start, abort, src_addr, dst_addr, length, mem_rdata,
        output busy, done, err, words_done,
               mem_en_r, mem_en_w, mem_address, mem_wdata
    );

    modport slave (
        output start, abort, src_addr, dst_addr, length, mem_rdata,
        input  busy, done, err, words_done,
               mem_en_r, mem_en_w, mem_address, mem_wdata
    );
endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine
// Single-channel memory-to-memory copy engine. For each word it does one
// read access and then one write access on a RAM. The RAM latches the
// address on a rising edge and acts on the following falling edge, so each
// access is held for two cycles.
// Ports:
//   clock   : system clock; all state changes on the rising edge
//   reset_n : synchronous, active-low reset
//   bus     : dma_copy_engine_if.master. It carries the host controls
//             (start/abort/src/dst/length), the status outputs
//             (busy/done/err/words_done) and the RAM port
//             (en_r/en_w/address/wdata/rdata).
module dma_copy_engine #(
    parameter int ADDR_W    = 65,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 7,
    parameter int MEM_DEPTH = 65
) (
    input  logic                  clock,
    input  logic                  reset_n,
    dma_copy_engine_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_WAIT, WR_ADDR, WR_HOLD, DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state, next_state;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [ADDR_W:0]   src_end, dst_end;
    logic              range_bad;
    logic              in_busy;
    logic              abort_hit;

    // The end addresses are computed one bit wider so that a wrap cannot
    // hide an overflow.
    always_comb begin
        src_end   = {1'b0, bus.src_addr} + (ADDR_W+1)'(bus.length);
        dst_end   = {1'b0, bus.dst_addr} + (ADDR_W+1)'(bus.length);
        range_bad = (bus.length == '0) || (src_end > DEPTH) || (dst_end > DEPTH);
    end

    assign in_busy   = (state != IDLE) && (state != DONE);
    assign abort_hit = in_busy && bus.abort;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = range_bad ? DONE : RD_ADDR;
            RD_ADDR: next_state = RD_WAIT;
            RD_WAIT: next_state = WR_ADDR;
            WR_ADDR: next_state = WR_HOLD;
            WR_HOLD: next_state = (remaining == LEN_W'(1)) ? DONE : RD_ADDR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_hit) next_state = DONE;
    end

    // All outputs are registered. The flag outputs are decoded from
    // next_state, so an abort drops both enables on the same edge that
    // enters DONE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= IDLE;
            src_ptr         <= '0;
            dst_ptr         <= '0;
            remaining       <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            bus.words_done  <= '0;
            bus.mem_en_r    <= 1'b0;
            bus.mem_en_w    <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
        end else begin
            state        <= next_state;
            bus.busy     <= (next_state == RD_ADDR) || (next_state == RD_WAIT) ||
                            (next_state == WR_ADDR) || (next_state == WR_HOLD);
            bus.done     <= (next_state == DONE);
            bus.mem_en_r <= (next_state == RD_ADDR) || (next_state == RD_WAIT);
            bus.mem_en_w <= (next_state == WR_ADDR) || (next_state == WR_HOLD);

            if (abort_hit) begin
                // A write already issued in WR_HOLD is not counted.
                bus.err <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        src_ptr        <= bus.src_addr;
                        dst_ptr        <= bus.dst_addr;
                        remaining      <= bus.length;
                        bus.words_done <= '0;
                        bus.err        <= range_bad;
                        if (!range_bad) bus.mem_address <= bus.src_addr;
                    end
                    // mem_wdata is the data register. It is loaded on the
                    // same edge that sets up the write address.
                    RD_WAIT: begin
                        bus.mem_wdata   <= bus.mem_rdata;
                        bus.mem_address <= dst_ptr;
                    end
                    WR_HOLD: begin
                        src_ptr        <= src_ptr + ADDR_W'(1);
                        dst_ptr        <= dst_ptr + ADDR_W'(1);
                        remaining      <= remaining - LEN_W'(1);
                        bus.words_done <= bus.words_done + LEN_W'(1);
                        if (remaining != LEN_W'(1))
                            bus.mem_address <= src_ptr + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
